// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor built from a single
// full_subtractor cell and a registered borrow.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid / in_ready     operand handshake (accepted only in IDLE)
//   minuend, subtrahend     WIDTH-bit operands, sampled on input handshake
//   borrow_in               borrow into bit 0, sampled on input handshake
//   out_valid / out_ready   result handshake (valid only in DONE)
//   diff                    (minuend - subtrahend - borrow_in) mod 2^WIDTH
//   borrow_out              unsigned borrow out of the MSB
//   overflow                signed overflow (borrow into MSB ^ borrow out of MSB)
//   busy                    high while bits are being processed (SHIFT)

// One-bit full subtractor: diff = a - b - bin, bout = borrow out.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);

   assign diff = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] minuend,
   input  logic [WIDTH-1:0] subtrahend,
   input  logic             borrow_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             overflow,
   output logic             busy
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] result_next;
   logic [CNT_W-1:0] cnt;
   logic             borrow_q;

   logic             fs_diff;
   logic             fs_bout;
   logic             accept;
   logic             last_bit;
   logic             out_fire;
   logic             msb_borrow_in;

   // The single arithmetic cell; everything else sequences its inputs.
   full_subtractor u_cell (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .bin  (borrow_q),
      .diff (fs_diff),
      .bout (fs_bout)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake decode.
   always_comb begin
      state_next    = state;
      accept        = 1'b0;
      out_fire      = 1'b0;
      last_bit      = (cnt == CNT_W'(WIDTH - 1));
      // Borrow entering the MSB is the registered borrow on the last bit cycle.
      msb_borrow_in = borrow_q;
      // New difference bit enters at the MSB; the old LSB falls off.
      result_next   = WIDTH'({fs_diff, result} >> 1);

      case (state)
         IDLE: begin
            if (in_valid) begin
               accept     = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (last_bit) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_fire   = 1'b1;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Operand shift registers, borrow chain, bit counter and partial result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sh     <= '0;
         b_sh     <= '0;
         result   <= '0;
         cnt      <= '0;
         borrow_q <= 1'b0;
      end else if (accept) begin
         a_sh     <= minuend;
         b_sh     <= subtrahend;
         result   <= '0;
         cnt      <= '0;
         borrow_q <= borrow_in;
      end else if (state == SHIFT) begin
         a_sh     <= a_sh >> 1;
         b_sh     <= b_sh >> 1;
         result   <= result_next;
         cnt      <= cnt + CNT_W'(1);
         borrow_q <= fs_bout;
      end
   end

   // Published result; updated only when the final bit completes so the
   // previous answer stays visible through the next operation.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         diff       <= '0;
         borrow_out <= 1'b0;
         overflow   <= 1'b0;
      end else if ((state == SHIFT) && last_bit) begin
         diff       <= result_next;
         borrow_out <= fs_bout;
         overflow   <= msb_borrow_in ^ fs_bout;
      end
   end

   // Status flags are registered decodes of the next state, so they equal a
   // decode of the current state with no path from in_valid/out_ready.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         in_ready  <= (state_next == IDLE);
         out_valid <= (state_next == DONE);
         busy      <= (state_next == SHIFT);
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for serial_subtractor at WIDTH=8
// and WIDTH=2. Expected results are queued on input acceptance and popped
// when the DUT presents a result.
module tb_serial_subtractor;

   typedef struct packed {
      logic        ovf;
      logic        bo;
      logic [63:0] d;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;

   logic       iv8, ir8, ov8, or8, bi8, bo8, of8, bz8;
   logic [7:0] a8, b8, d8;

   logic       iv2, ir2, ov2, or2, bi2, bo2, of2, bz2;
   logic [1:0] a2, b2, d2;

   int n_checks = 0;
   int n_errors = 0;

   exp_t q8[$];
   exp_t q2[$];

   serial_subtractor #(.WIDTH(8)) u_dut8 (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (iv8),
      .in_ready   (ir8),
      .minuend    (a8),
      .subtrahend (b8),
      .borrow_in  (bi8),
      .out_valid  (ov8),
      .out_ready  (or8),
      .diff       (d8),
      .borrow_out (bo8),
      .overflow   (of8),
      .busy       (bz8)
   );

   serial_subtractor #(.WIDTH(2)) u_dut2 (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (iv2),
      .in_ready   (ir2),
      .minuend    (a2),
      .subtrahend (b2),
      .borrow_in  (bi2),
      .out_valid  (ov2),
      .out_ready  (or2),
      .diff       (d2),
      .borrow_out (bo2),
      .overflow   (of2),
      .busy       (bz2)
   );

   // Reference: wide subtraction, borrow from the extra bit, signed overflow
   // from operand/result signs.
   function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                  input logic bin, input int w);
      exp_t        e;
      logic [63:0] mask;
      logic [64:0] r;
      mask  = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      r     = {1'b0, a & mask} - {1'b0, b & mask} - {64'd0, bin};
      e.d   = r[63:0] & mask;
      e.bo  = r[64];
      e.ovf = (a[w-1] != b[w-1]) && (e.d[w-1] != a[w-1]);
      return e;
   endfunction

   // Drive one operand set into the 8-bit DUT (assumed IDLE) and wait for
   // out_valid, reporting the latency in cycles and any non-busy SHIFT cycle.
   task automatic start_op8(input logic [7:0] a, input logic [7:0] b,
                            input logic bin, output int lat, output int busy_bad);
      @(negedge clk);
      a8 = a; b8 = b; bi8 = bin; iv8 = 1'b1; or8 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      iv8 = 1'b0;
      lat = 0;
      busy_bad = 0;
      while (!ov8 && lat < 40) begin
         if (bz8 !== 1'b1) busy_bad++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset;
      iv8 = 1'b1; a8 = 8'hAA; b8 = 8'h11; bi8 = 1'b1;
      iv2 = 1'b1; a2 = 2'b10; b2 = 2'b01;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({ir8, ov8, bz8, d8, bo8, of8} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
         n_errors++;
         $display("FAIL reset8: ir=%b ov=%b busy=%b diff=%h bo=%b of=%b, want 1 0 0 00 0 0",
                  ir8, ov8, bz8, d8, bo8, of8);
      end
      n_checks++;
      if ({ir2, ov2, bz2, d2, bo2, of2} !== {1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0}) begin
         n_errors++;
         $display("FAIL reset2: ir=%b ov=%b busy=%b diff=%h bo=%b of=%b, want 1 0 0 0 0 0",
                  ir2, ov2, bz2, d2, bo2, of2);
      end
      rst_n = 1'b1;
      iv8 = 1'b0;
      iv2 = 1'b0;
      @(negedge clk);
      // in_valid was high during reset; nothing may have been captured.
      n_checks++;
      if ({ir8, bz8} !== 2'b10) begin
         n_errors++;
         $display("FAIL reset_wins: ir=%b busy=%b, want 1 0", ir8, bz8);
      end
   endtask

   task automatic test_basic;
      logic [7:0] ta[5] = '{8'h5A, 8'h00, 8'h80, 8'h10, 8'h0F};
      logic [7:0] tb[5] = '{8'h23, 8'h01, 8'h01, 8'h0F, 8'h0F};
      logic       tc[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [7:0] td[5] = '{8'h37, 8'hFF, 8'h7F, 8'h00, 8'hFF};
      logic       tbo[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic       tof[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      int lat, busy_bad;
      exp_t e;
      for (int i = 0; i < 5; i++) begin
         q8.push_back(exp_t'{tof[i], tbo[i], {56'd0, td[i]}});
         start_op8(ta[i], tb[i], tc[i], lat, busy_bad);
         n_checks++;
         if (lat != 8 || busy_bad != 0) begin
            n_errors++;
            $display("FAIL latency[%0d]: out_valid after %0d cycles, %0d idle shift cycles, want 8 and 0",
                     i, lat, busy_bad);
         end
         e = q8.pop_front();
         n_checks++;
         if ({of8, bo8, d8, bz8, ir8} !== {e.ovf, e.bo, e.d[7:0], 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL result[%0d]: of=%b bo=%b diff=%h busy=%b ir=%b, want of=%b bo=%b diff=%h busy=0 ir=0",
                     i, of8, bo8, d8, bz8, ir8, e.ovf, e.bo, e.d[7:0]);
         end
         or8 = 1'b1;
         @(posedge clk);
         @(negedge clk);
         or8 = 1'b0;
      end
   endtask

   task automatic test_backpressure;
      int lat, busy_bad;
      exp_t e;
      q8.push_back(model(64'h5A, 64'h23, 1'b0, 8));
      start_op8(8'h5A, 8'h23, 1'b0, lat, busy_bad);
      for (int i = 0; i < 5; i++) begin
         iv8 = ~iv8;
         a8  = 8'($urandom);
         b8  = 8'($urandom);
         bi8 = 1'($urandom);
         @(negedge clk);
         n_checks++;
         if ({ov8, d8, ir8, bz8} !== {1'b1, 8'h37, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL stall[%0d]: ov=%b diff=%h ir=%b busy=%b, want 1 37 0 0",
                     i, ov8, d8, ir8, bz8);
         end
      end
      e = q8.pop_front();
      n_checks++;
      if ({of8, bo8, d8} !== {e.ovf, e.bo, e.d[7:0]}) begin
         n_errors++;
         $display("FAIL stall_result: of=%b bo=%b diff=%h, want %b %b %h",
                  of8, bo8, d8, e.ovf, e.bo, e.d[7:0]);
      end
      iv8 = 1'b0;
      or8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      or8 = 1'b0;
      n_checks++;
      if ({ir8, ov8, bz8} !== 3'b100) begin
         n_errors++;
         $display("FAIL release: ir=%b ov=%b busy=%b, want 1 0 0", ir8, ov8, bz8);
      end
   endtask

   task automatic test_reset_mid;
      int lat, busy_bad;
      exp_t e;
      @(negedge clk);
      a8 = 8'hFF; b8 = 8'h01; bi8 = 1'b0; iv8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      iv8 = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (bz8 !== 1'b1) begin
         n_errors++;
         $display("FAIL mid_busy: busy=%b, want 1", bz8);
      end
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      n_checks++;
      if ({ir8, ov8, bz8, d8} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
         n_errors++;
         $display("FAIL mid_reset: ir=%b ov=%b busy=%b diff=%h, want 1 0 0 00",
                  ir8, ov8, bz8, d8);
      end
      q8.push_back(exp_t'{1'b0, 1'b0, 64'd0});
      start_op8(8'h01, 8'h01, 1'b0, lat, busy_bad);
      e = q8.pop_front();
      n_checks++;
      if (lat != 8 || {of8, bo8, d8} !== {e.ovf, e.bo, e.d[7:0]}) begin
         n_errors++;
         $display("FAIL after_reset: lat=%0d of=%b bo=%b diff=%h, want 8 0 0 00",
                  lat, of8, bo8, d8);
      end
      or8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      or8 = 1'b0;
   endtask

   task automatic test_back_to_back;
      int   sent8 = 0, sent2 = 0, got8 = 0, got2 = 0;
      int   last8 = -1, last2 = -1;
      exp_t e;
      or8 = 1'b1;
      or2 = 1'b1;
      for (int c = 0; c < 12000 && (got8 < 1000 || got2 < 1000); c++) begin
         @(negedge clk);
         if (ov8) begin
            n_checks++;
            if (q8.size() == 0) begin
               n_errors++;
               $display("FAIL b2b8: unexpected result diff=%h", d8);
            end else begin
               e = q8.pop_front();
               if ({of8, bo8, d8} !== {e.ovf, e.bo, e.d[7:0]}) begin
                  n_errors++;
                  $display("FAIL b2b8[%0d]: of=%b bo=%b diff=%h, want %b %b %h",
                           got8, of8, bo8, d8, e.ovf, e.bo, e.d[7:0]);
               end
            end
            if (last8 >= 0) begin
               n_checks++;
               if (c - last8 != 10) begin
                  n_errors++;
                  $display("FAIL period8: %0d cycles between results, want 10", c - last8);
               end
            end
            last8 = c;
            got8++;
         end
         if (ir8 && sent8 < 1000) begin
            iv8 = 1'b1;
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            bi8 = 1'($urandom_range(0, 1));
            q8.push_back(model({56'd0, a8}, {56'd0, b8}, bi8, 8));
            sent8++;
         end else if (ir8) begin
            iv8 = 1'b0;
         end else begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
         end

         if (ov2) begin
            n_checks++;
            if (q2.size() == 0) begin
               n_errors++;
               $display("FAIL b2b2: unexpected result diff=%h", d2);
            end else begin
               e = q2.pop_front();
               if ({of2, bo2, d2} !== {e.ovf, e.bo, e.d[1:0]}) begin
                  n_errors++;
                  $display("FAIL b2b2[%0d]: of=%b bo=%b diff=%h, want %b %b %h",
                           got2, of2, bo2, d2, e.ovf, e.bo, e.d[1:0]);
               end
            end
            if (last2 >= 0) begin
               n_checks++;
               if (c - last2 != 4) begin
                  n_errors++;
                  $display("FAIL period2: %0d cycles between results, want 4", c - last2);
               end
            end
            last2 = c;
            got2++;
         end
         if (ir2 && sent2 < 1000) begin
            iv2 = 1'b1;
            a2  = 2'($urandom);
            b2  = 2'($urandom);
            bi2 = 1'($urandom_range(0, 1));
            q2.push_back(model({62'd0, a2}, {62'd0, b2}, bi2, 2));
            sent2++;
         end else if (ir2) begin
            iv2 = 1'b0;
         end else begin
            a2 = 2'($urandom);
            b2 = 2'($urandom);
         end
      end
      n_checks++;
      if (got8 != 1000 || got2 != 1000 || q8.size() != 0 || q2.size() != 0) begin
         n_errors++;
         $display("FAIL b2b_count: got8=%0d got2=%0d pending8=%0d pending2=%0d, want 1000 1000 0 0",
                  got8, got2, q8.size(), q2.size());
      end
   endtask

   initial begin
      rst_n = 1'b0;
      iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; bi8 = 1'b0;
      iv2 = 1'b0; or2 = 1'b0; a2 = '0; b2 = '0; bi2 = 1'b0;
      test_reset;
      test_basic;
      test_backpressure;
      test_reset_mid;
      test_back_to_back;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial multi-bit subtractor built around one `full_subtractor` cell and a registered borrow. It accepts two WIDTH-bit unsigned/two's-complement operands plus a borrow-in over a valid/ready handshake. It feeds the cell one bit pair per clock, LSB first, and shifts the cell's difference bit into a result register. It sits directly upstream of the cell, sequencing its inputs and consuming its `diff`/`borrow_out` every cycle. It is the area-minimal subtract path for the arithmetic datapath.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range 2..64.
- `clk`  in  1: sole clock; all state updates on rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `in_valid`  in  1: operands valid.
- `in_ready`  out  1: block can accept operands; high only in IDLE.
- `minuend`  in  WIDTH: operand A, sampled on input handshake.
- `subtrahend`  in  WIDTH: operand B, sampled on input handshake.
- `borrow_in`  in  1: initial borrow into bit 0, sampled on input handshake.
- `out_valid`  out  1: result valid; high only in DONE.
- `out_ready`  in  1: consumer accepts result.
- `diff`  out  WIDTH: (A − B − borrow_in) mod 2^WIDTH.
- `borrow_out`  out  1: 1 iff A < B + borrow_in (unsigned).
- `overflow`  out  1: signed overflow = borrow into MSB XOR borrow out of MSB.
- `busy`  out  1: high in SHIFT.

## Operation
- States: IDLE, SHIFT, DONE.
  - IDLE → SHIFT on `in_valid && in_ready`.
  - SHIFT → DONE after bit WIDTH−1 is processed.
  - DONE → IDLE on `out_valid && out_ready`.
- Input handshake: load A and B into shift registers, load `borrow_in` into the borrow register, clear the bit counter (width clog2(WIDTH)) and the result register.
- Each SHIFT cycle:
  - The `full_subtractor` instance sees A[0], B[0] and the borrow register.
  - A and B shift right by one.
  - The cell's `diff` is shifted in at the result MSB, so after WIDTH cycles bit 0 lands at the LSB.
  - The borrow register takes the cell's `borrow_out`.
  - The counter increments.
- On the MSB cycle (counter = WIDTH−1), the incoming borrow register value is captured as `msb_borrow_in` so that `overflow` can be computed.
- `diff`, `borrow_out` and `overflow` are registered. They are held stable for the whole of DONE, and until the next result is complete.
- Input handshake is never accepted outside IDLE. `in_valid` during SHIFT/DONE is ignored, and operand changes then have no effect.
- No bypass: after the output handshake, `in_ready` rises in the following cycle (IDLE).

## Timing
- Reset (`rst_n` low at an edge): state IDLE; counter, shift registers, borrow and result registers cleared.
  - Outputs after the reset edge: `in_ready`=1, `out_valid`=0, `busy`=0, `diff`=0, `borrow_out`=0, `overflow`=0.
  - `rst_n` overrides every other input in the same cycle.
- Latency: input handshake at edge t0 gives `busy`=1 in cycles t0+1..t0+WIDTH, and `out_valid`=1 from t0+WIDTH.
- Throughput: one result per WIDTH+2 cycles when `out_ready` is held high.
- Backpressure: with `out_ready` low, DONE persists indefinitely and all outputs hold.
- Reset mid-SHIFT or mid-DONE: the operation is abandoned and no result is emitted. The first cycle after the reset edge shows IDLE values.
- Reset asserted in the same cycle as `in_valid`: reset wins and the operands are not captured.
- `in_ready` and `out_valid` are pure state decodes (no combinational path from `in_valid`/`out_ready`).

## Test plan
- WIDTH=8, A=0x5A, B=0x23, `borrow_in`=0 → after 8 busy cycles: `diff`=0x37, `borrow_out`=0, `overflow`=0; `out_valid` exactly 8 cycles after accept.
- A=0x00, B=0x01, `borrow_in`=0 → `diff`=0xFF, `borrow_out`=1, `overflow`=0. Then A=0x80, B=0x01 → `diff`=0x7F, `borrow_out`=0, `overflow`=1.
- A=0x10, B=0x0F, `borrow_in`=1 → `diff`=0x00, `borrow_out`=0. Then A=0x0F, B=0x0F, `borrow_in`=1 → `diff`=0xFF, `borrow_out`=1.
- Hold `out_ready`=0 for 5 cycles in DONE while toggling `in_valid` and operands → `out_valid` and `diff` are unchanged, `in_ready`=0, and no new operation starts. Raising `out_ready` gives IDLE next cycle.
- Pull `rst_n` low when the counter = 3 → next cycle: IDLE, `in_ready`=1, `out_valid`=0, `diff`=0. A fresh operation (0x01−0x01) then yields 0x00.
- Back-to-back random operands with `out_ready`=1 and `in_valid`=1, 1000 vectors, both WIDTH=8 and WIDTH=2:
  - every result matches the reference model (A−B−bin mod 2^WIDTH, borrow, signed overflow);
  - results arrive one per WIDTH+2 cycles.
